// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative shift-add multiplier / restoring divider with start/busy/done handshake.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;
    state_t           state;
    logic [WIDTH-1:0] mag_b, wh, wl, abs_a, abs_b;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, is_div, dz, sa, sb;
    logic [WIDTH:0]   sum, trial, diff;
    always_comb begin
        sa    = is_signed & op_a[WIDTH-1];
        sb    = is_signed & op_b[WIDTH-1];
        abs_a = sa ? -op_a : op_a;
        abs_b = sb ? -op_b : op_b;
        sum   = wl[0] ? {1'b0, wh} + {1'b0, mag_b} : {1'b0, wh};
        trial = {wh, wl[WIDTH-1]};
        diff  = trial - {1'b0, mag_b};
    end
    // wh/wl hold the running product halves during MULT and remainder/quotient during DIV
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            mag_b    <= '0;
            wh       <= '0;
            wl       <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_mult || start_div) begin
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        is_div   <= !start_mult;
                        dz       <= !start_mult && op_b == '0;
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        mag_b    <= abs_b;
                        wh       <= '0;
                        wl       <= abs_a;
                        cnt      <= CW'(WIDTH);
                        state    <= start_mult ? MULT : (op_b == '0 ? FINISH : DIV);
                    end
                end
                MULT: begin
                    {wh, wl} <= {sum, wl[WIDTH-1:1]};
                    cnt      <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FINISH;
                end
                DIV: begin
                    wh    <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                    wl    <= {wl[WIDTH-2:0], !diff[WIDTH]};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FINISH;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (dz) div_zero <= 1'b1;
                    else if (is_div) begin
                        lo_out <= neg_q ? -wl : wl;
                        hi_out <= neg_r ? -wh : wh;
                    end else {hi_out, lo_out} <= neg_q ? -{wh, wl} : {wh, wl};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: random and directed checking of mult_div_seq against a cycle-count reference model.
module tb_mult_div_seq;
    logic        clock = 0, reset = 1, start_mult = 0, start_div = 0, is_signed = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;
    int          vectors = 0, miscompares = 0;

    mult_div_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .is_signed(is_signed), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: results from 64-bit arithmetic, timing as a countdown of cycles to done
    logic        exp_busy = 0, exp_done = 0, exp_dz = 0, pend_dz = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0, pend_hi = 0, pend_lo = 0;
    int          left = 0;
    always @(posedge clock) begin
        logic [63:0] ea, eb, p, q, r;
        exp_done = 0;
        if (reset) begin
            {exp_busy, exp_dz, exp_hi, exp_lo} = '0;
            left = 0;
        end else if (left == 0) begin
            if (start_mult || start_div) begin
                ea = is_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
                eb = is_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
                exp_dz = 0;
                exp_busy = 1;
                pend_dz = !start_mult && op_b == 0;
                if (start_mult) begin
                    p = is_signed ? 64'($signed(ea) * $signed(eb)) : ea * eb;
                    {pend_hi, pend_lo} = p;
                end else if (!pend_dz) begin
                    q = is_signed ? 64'($signed(ea) / $signed(eb)) : ea / eb;
                    r = is_signed ? 64'($signed(ea) % $signed(eb)) : ea % eb;
                    pend_hi = r[31:0];
                    pend_lo = q[31:0];
                end
                left = pend_dz ? 1 : 33;
            end
        end else begin
            left--;
            if (left == 0) begin
                exp_busy = 0;
                exp_done = 1;
                exp_dz = pend_dz;
                if (!pend_dz) begin
                    exp_hi = pend_hi;
                    exp_lo = pend_lo;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        chk("div_zero", 64'(div_zero), 64'(exp_dz));
        chk("hi_out", 64'(hi_out), 64'(exp_hi));
        chk("lo_out", 64'(lo_out), 64'(exp_lo));
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = done;
        end
        chk("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic run(input bit bb, input logic m, d, s, input logic [31:0] a, b);
        if (!bb) @(posedge clock);
        #1;
        start_mult = m; start_div = d; is_signed = s; op_a = a; op_b = b;
        @(posedge clock); #1;
        start_mult = 0; start_div = 0;
        wait_done();
    endtask

    task automatic lit(input string name, input logic [31:0] h, l);
        chk({name, "_hi"}, 64'(hi_out), 64'(h));
        chk({name, "_lo"}, 64'(lo_out), 64'(l));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int busy_cycles;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        lit("reset", 32'h0, 32'h0);
        chk("reset_busy", 64'(busy), 64'(0));
        // 1: signed -3*5, with busy length counted
        @(posedge clock); #1;
        start_mult = 1; is_signed = 1; op_a = 32'hFFFFFFFD; op_b = 32'd5;
        @(posedge clock); #1;
        start_mult = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
        end
        chk("busy_len", 64'(busy_cycles), 64'(33));
        lit("smul", 32'hFFFFFFFF, 32'hFFFFFFF1);
        // 2
        run(0, 1, 0, 0, 32'hFFFFFFFF, 32'd2);  lit("umul", 32'h1, 32'hFFFFFFFE);
        run(0, 1, 0, 1, 32'hFFFFFFFF, 32'd2);  lit("smul2", 32'hFFFFFFFF, 32'hFFFFFFFE);
        // 3
        run(0, 0, 1, 1, 32'hFFFFFFF9, 32'd2);  lit("sdiv", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run(0, 0, 1, 0, 32'd7, 32'd2);         lit("udiv", 32'h1, 32'h3);
        run(0, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF); lit("ovf", 32'h0, 32'h80000000);
        // 4: divide by zero keeps the previous results
        run(0, 0, 1, 1, 32'd9, 32'd0);
        lit("dz", 32'h0, 32'h80000000);
        chk("dz_flag", 64'(div_zero), 64'(1));
        run(1, 0, 1, 0, 32'd20, 32'd6);
        lit("after_dz", 32'h2, 32'h3);
        // 5: both starts -> multiply; a stray divide start mid-operation is ignored
        @(posedge clock); #1;
        start_mult = 1; start_div = 1; is_signed = 0; op_a = 32'd6; op_b = 32'd7;
        @(posedge clock); #1;
        start_mult = 0; start_div = 0;
        repeat (4) @(posedge clock);
        #1 start_div = 1; op_a = 32'd100; op_b = 32'd3;
        @(posedge clock); #1 start_div = 0;
        wait_done();
        lit("both", 32'h0, 32'd42);
        repeat (40) @(negedge clock);
        // 6: reset in the middle of a divide
        @(posedge clock); #1;
        start_div = 1; is_signed = 0; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clock); #1 start_div = 0;
        repeat (9) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        start_mult = 1; is_signed = 1; op_a = 32'hFFFFFFFE; op_b = 32'hFFFFFFFD;
        @(negedge clock);
        lit("rst_mid", 32'h0, 32'h0);
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clock); #1 start_mult = 0;
        wait_done();
        lit("post_rst", 32'h0, 32'd6);
        // random traffic, sometimes issued back-to-back in the done cycle
        for (int n = 0; n < 200; n++) begin
            logic m, d;
            m = $urandom_range(0, 1);
            d = !m | ($urandom_range(0, 3) == 0);
            run($urandom_range(0, 1), m, d, $urandom_range(0, 1), pick(), pick());
        end
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
